mem_arb_ctrl: RTL and testbench

//  Owns the single byte-wide RAM port and shares it between instruction fetch (IF) and the MEM stage.

---
 rtl/mem_arb_ctrl_pkg.sv | 12 +
 rtl/mem_arb_ctrl_stall_encoder.sv | 22 ++
 rtl/mem_arb_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_arb_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_ctrl_pkg.sv
// mem_arb_ctrl_pkg: shared FSM states, access-size encodings and stall patterns for mem_arb_ctrl
package mem_arb_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_e;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [5:0] STALL_MEM = 6'b011111;
  localparam logic [5:0] STALL_ID = 6'b000111;
  localparam logic [5:0] STALL_IF = 6'b000011;
  function automatic logic [1:0] size_last(input logic [1:0] size);
    return size == SZ_BYTE ? 2'd0 : size == SZ_HALF ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/mem_arb_ctrl_stall_encoder.sv
// mem_arb_ctrl_stall_encoder: priority-encodes pipeline stall requests into the per-stage stall vector
//   in  rst, mem_req, mem_ack, id_stallreq, if_req, if_ack
//   out stall_sign[STALL_W]  bit0 pc .. bit5 wb
module mem_arb_ctrl_stall_encoder
  import mem_arb_ctrl_pkg::*;
#(
  parameter int STALL_W = 6
) (
  input  logic               rst,
  input  logic               mem_req,
  input  logic               mem_ack,
  input  logic               id_stallreq,
  input  logic               if_req,
  input  logic               if_ack,
  output logic [STALL_W-1:0] stall_sign
);
  always_comb
    stall_sign = rst                  ? '0 :
                 mem_req && !mem_ack  ? STALL_W'(STALL_MEM) :
                 id_stallreq          ? STALL_W'(STALL_ID) :
                 if_req && !if_ack    ? STALL_W'(STALL_IF) : '0;
endmodule

// File: rtl/mem_arb_ctrl.sv
// mem_arb_ctrl: arbitrates the byte-wide RAM port between instruction fetch and MEM, serialising accesses
//   in  clk, rst, if_req/if_addr, mem_req/mem_we/mem_size/mem_addr/mem_wdata, id_stallreq, ram_din
//   out if_ack/if_inst, mem_ack/mem_rdata, ram_a/ram_dout/ram_wr, stall_sign
module mem_arb_ctrl
  import mem_arb_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_ack,
  output logic [31:0]        if_inst,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [1:0]         mem_size,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic               mem_ack,
  output logic [31:0]        mem_rdata,
  input  logic               id_stallreq,
  input  logic [7:0]         ram_din,
  output logic [7:0]         ram_dout,
  output logic [ADDR_W-1:0]  ram_a,
  output logic               ram_wr,
  output logic [STALL_W-1:0] stall_sign
);
  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [1:0] last_q, last_d;
  logic [31:0] buf_q, buf_d, if_inst_q, if_inst_d, mem_rdata_q, mem_rdata_d, merged;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0] ram_dout_q, ram_dout_d;
  logic ram_wr_q, ram_wr_d, if_ack_q, if_ack_d, mem_ack_q, mem_ack_d;
  logic [1:0] rlane, wlane;
  // cnt counts cycles in the access; a read byte addressed on cycle k lands on cycle k+1 in lane k
  always_comb begin
    rlane = cnt_q[1:0] - 2'd1;
    wlane = cnt_q[1:0] + 2'd1;
    merged = buf_q;
    merged[{rlane, 3'b000} +: 8] = ram_din;
    state_d = state_q;
    cnt_d = cnt_q;
    last_d = last_q;
    buf_d = buf_q;
    ram_a_d = ram_a_q;
    ram_dout_d = ram_dout_q;
    ram_wr_d = 1'b0;
    if_ack_d = 1'b0;
    mem_ack_d = 1'b0;
    if_inst_d = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE:
        if (mem_req) begin
          state_d = mem_we ? MEM_WR : MEM_RD;
          cnt_d = '0;
          last_d = size_last(mem_size);
          buf_d = '0;
          ram_a_d = mem_addr;
          ram_dout_d = mem_wdata[7:0];
          ram_wr_d = mem_we;
        end else if (if_req) begin
          state_d = IF_RD;
          cnt_d = '0;
          last_d = 2'd3;
          buf_d = '0;
          ram_a_d = if_addr;
        end
      IF_RD, MEM_RD:
        if (state_q == IF_RD && !if_req) state_d = IDLE;
        else begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q != 3'd0) buf_d = merged;
          if (cnt_q < {1'b0, last_q}) ram_a_d = ram_a_q + ADDR_W'(1);
          if (cnt_q == {1'b0, last_q} + 3'd1) begin
            state_d = DONE;
            if_ack_d = state_q == IF_RD;
            mem_ack_d = state_q == MEM_RD;
            if_inst_d = state_q == IF_RD ? merged : if_inst_q;
            mem_rdata_d = state_q == MEM_RD ? merged : mem_rdata_q;
          end
        end
      MEM_WR:
        if (cnt_q[1:0] == last_q) begin
          state_d = DONE;
          mem_ack_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 3'd1;
          ram_a_d = ram_a_q + ADDR_W'(1);
          ram_dout_d = mem_wdata[{wlane, 3'b000} +: 8];
          ram_wr_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      last_q <= '0;
      buf_q <= '0;
      ram_a_q <= '0;
      ram_dout_q <= '0;
      ram_wr_q <= 1'b0;
      if_ack_q <= 1'b0;
      mem_ack_q <= 1'b0;
      if_inst_q <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      buf_q <= buf_d;
      ram_a_q <= ram_a_d;
      ram_dout_q <= ram_dout_d;
      ram_wr_q <= ram_wr_d;
      if_ack_q <= if_ack_d;
      mem_ack_q <= mem_ack_d;
      if_inst_q <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end
  assign ram_a = ram_a_q;
  assign ram_dout = ram_dout_q;
  assign ram_wr = ram_wr_q;
  assign if_ack = if_ack_q;
  assign mem_ack = mem_ack_q;
  assign if_inst = if_inst_q;
  assign mem_rdata = mem_rdata_q;
  mem_arb_ctrl_stall_encoder #(.STALL_W(STALL_W)) u_stall (
    .rst(rst),
    .mem_req(mem_req),
    .mem_ack(mem_ack_q),
    .id_stallreq(id_stallreq),
    .if_req(if_req),
    .if_ack(if_ack_q),
    .stall_sign(stall_sign)
  );
endmodule

// File: tb/tb_mem_arb_ctrl.sv
// tb_mem_arb_ctrl: directed, table-driven bench for mem_arb_ctrl with a byte RAM model
module tb_mem_arb_ctrl;
  logic clk = 1'b0;
  logic rst, if_req, if_ack, mem_req, mem_we, mem_ack, id_stallreq, ram_wr;
  logic [31:0] if_addr, if_inst, mem_addr, mem_wdata, mem_rdata, ram_a;
  logic [1:0] mem_size;
  logic [7:0] ram_din, ram_dout;
  logic [5:0] stall_sign;
  logic [7:0] mem [0:4095];
  logic [31:0] wr_a[$], rd_a[$];
  logic [7:0] wr_d[$];
  int checks = 0, errors = 0;
  mem_arb_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .id_stallreq(id_stallreq), .ram_din(ram_din), .ram_dout(ram_dout),
    .ram_a(ram_a), .ram_wr(ram_wr), .stall_sign(stall_sign)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ram_din <= mem[ram_a[11:0]];
  typedef struct {
    logic is_if;
    logic we;
    logic [1:0] size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int n;
    logic [31:0] exp;
  } txn_t;
  typedef struct {
    logic i;
    logic m;
    logic d;
    logic [5:0] e;
  } sv_t;
  txn_t tv[11];
  sv_t st[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_txn(input txn_t t, output logic [31:0] data, output int lat);
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    if (t.is_if) begin
      if_req = 1'b1;
      if_addr = t.addr;
    end else begin
      mem_req = 1'b1;
      mem_we = t.we;
      mem_size = t.size;
      mem_addr = t.addr;
      mem_wdata = t.wdata;
    end
    lat = 0;
    data = 'x;
    for (int c = 0; c < 20; c++) begin
      tick();
      lat++;
      if (ram_wr) begin
        wr_a.push_back(ram_a);
        wr_d.push_back(ram_dout);
      end
      rd_a.push_back(ram_a);
      if (t.is_if ? if_ack : mem_ack) begin
        data = t.is_if ? if_inst : mem_rdata;
        break;
      end
    end
    if_req = 1'b0;
    mem_req = 1'b0;
    tick();
  endtask
  initial begin
    logic [31:0] d, held, wd, a;
    int lat, cnt, gap;
    logic seen_if;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 1);
    mem[12'h100] = 8'h13; mem[12'h101] = 8'h05; mem[12'h102] = 8'h00; mem[12'h103] = 8'h00;
    mem[12'h1FF] = 8'h99;
    mem[12'h200] = 8'h11; mem[12'h201] = 8'h22; mem[12'h202] = 8'h33; mem[12'h203] = 8'h44;
    mem[12'hFFF] = 8'hA5; mem[12'h000] = 8'h5A;
    tv[0]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 4, 32'h0000_0513};
    tv[1]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0200, 32'h0, 4, 32'h4433_2211};
    tv[2]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0200, 32'h0, 4, 32'h4433_2211};
    tv[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0202, 32'h0, 2, 32'h0000_4433};
    tv[4]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0201, 32'h0, 1, 32'h0000_0022};
    tv[5]  = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, 1, 32'h0000_00A5};
    tv[6]  = '{1'b0, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0, 2, 32'h0000_5AA5};
    tv[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_01FF, 32'h0, 4, 32'h3322_1199};
    tv[8]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0301, 32'hABCD_1234, 2, 32'h0};
    tv[9]  = '{1'b0, 1'b1, 2'd0, 32'h0000_0500, 32'h0000_0077, 1, 32'h0};
    tv[10] = '{1'b0, 1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0102_0304, 4, 32'h0};
    st[0] = '{1'b0, 1'b0, 1'b0, 6'b000000};
    st[1] = '{1'b0, 1'b0, 1'b1, 6'b000111};
    st[2] = '{1'b1, 1'b0, 1'b0, 6'b000011};
    st[3] = '{1'b0, 1'b1, 1'b0, 6'b011111};
    st[4] = '{1'b0, 1'b1, 1'b1, 6'b011111};
    st[5] = '{1'b1, 1'b0, 1'b1, 6'b000111};
    st[6] = '{1'b1, 1'b1, 1'b0, 6'b011111};
    rst = 1'b1; if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_size = 0;
    mem_addr = 0; mem_wdata = 0; id_stallreq = 0;
    tick();
    if_req = 1'b1; mem_req = 1'b1; id_stallreq = 1'b1;
    tick();
    chk("rst_stall", 32'(stall_sign), 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", 32'(ram_dout), 32'h0);
    chk("rst_ram_wr", 32'(ram_wr), 32'h0);
    chk("rst_acks", {30'h0, if_ack, mem_ack}, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    if_req = 0; mem_req = 0; id_stallreq = 0;
    rst = 1'b0;
    tick();
    for (int i = 0; i < 7; i++) begin
      if_req = st[i].i; mem_req = st[i].m; id_stallreq = st[i].d;
      #1;
      chk($sformatf("stall_vec%0d", i), 32'(stall_sign), 32'(st[i].e));
      if_req = 0; mem_req = 0; id_stallreq = 0;
      tick();
    end
    for (int i = 0; i < 11; i++) begin
      run_txn(tv[i], d, lat);
      chk($sformatf("lat%0d", i), lat, tv[i].we ? tv[i].n + 1 : tv[i].n + 2);
      if (!tv[i].we) begin
        chk($sformatf("data%0d", i), d, tv[i].exp);
        for (int k = 0; k < tv[i].n; k++)
          chk($sformatf("rd_addr%0d_%0d", i, k), rd_a.size() > k ? rd_a[k] : 32'hx, tv[i].addr + 32'(k));
      end else begin
        chk($sformatf("wr_count%0d", i), wr_a.size(), tv[i].n);
        wd = tv[i].wdata;
        for (int k = 0; k < tv[i].n && k < wr_a.size(); k++) begin
          chk($sformatf("wr_addr%0d_%0d", i, k), wr_a[k], tv[i].addr + 32'(k));
          chk($sformatf("wr_data%0d_%0d", i, k), 32'(wr_d[k]), 32'(wd[8*k +: 8]));
        end
      end
    end
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd2; mem_addr = 32'h200;
    seen_if = 1'b0; cnt = 0;
    for (int c = 0; c < 20 && !mem_ack; c++) begin
      tick();
      if (if_ack) seen_if = 1'b1;
      if (!mem_ack) begin
        chk("arb_stall_mem", 32'(stall_sign), 32'h1F);
        cnt++;
      end
    end
    chk("arb_mem_ack", 32'(mem_ack), 32'h1);
    chk("arb_mem_first", 32'(seen_if), 32'h0);
    chk("arb_mem_lat", cnt, 5);
    chk("arb_mem_data", mem_rdata, 32'h4433_2211);
    chk("arb_stall_done", 32'(stall_sign), 32'h03);
    mem_req = 1'b0;
    gap = 0;
    for (int c = 0; c < 20 && !if_ack; c++) begin
      tick();
      gap++;
    end
    chk("arb_if_gap", gap, 7);
    chk("arb_if_inst", if_inst, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    held = if_inst;
    if_req = 1'b1; if_addr = 32'h104;
    tick();
    tick();
    if_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (if_ack) cnt++;
    end
    chk("abort_no_ack", cnt, 0);
    chk("abort_inst_held", if_inst, held);
    run_txn(tv[4], d, lat);
    chk("abort_then_lb_lat", lat, 3);
    chk("abort_then_lb_data", d, 32'h22);
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h400; mem_wdata = 32'hDEAD_BEEF;
    tick();
    chk("sw_started", 32'(ram_wr), 32'h1);
    rst = 1'b1;
    tick();
    a = ram_a;
    chk("rst_mid_wr", 32'(ram_wr), 32'h0);
    chk("rst_mid_ack", 32'(mem_ack), 32'h0);
    chk("rst_mid_stall", 32'(stall_sign), 32'h0);
    chk("rst_mid_addr", a, 32'h0);
    rst = 1'b0; mem_req = 1'b0;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mem_ack || ram_wr) cnt++;
    end
    chk("rst_mid_quiet", cnt, 0);
    id_stallreq = 1'b1;
    #1;
    chk("id_stall_only", 32'(stall_sign), 32'h07);
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h201;
    #1;
    chk("id_with_mem", 32'(stall_sign), 32'h1F);
    mem_req = 1'b0; id_stallreq = 1'b0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
